// File: rtl/neo_pkg.sv
// Shared widths and types for the streaming NEO block.
package neo_pkg;

  localparam int NEO_CH_DEFAULT = 4;

  function automatic int psi_width(input int n);
    return 2 * n + 1;
  endfunction

  function automatic int chw(input int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

  typedef logic [chw(NEO_CH_DEFAULT)-1:0] neo_ch_t;

endpackage

// File: rtl/neo_tap_line.sv
// One channel's 2K+1 sample window (tap0 newest) plus a saturating fill counter.
module neo_tap_line
  import neo_pkg::*;
#(
  parameter int N = 16,
  parameter int K = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                shift_en_i,
  input  logic signed [N-1:0] din_i,
  output logic signed [N-1:0] tap0_o,
  output logic signed [N-1:0] tapk_o,
  output logic signed [N-1:0] tap2k_o,
  output logic                warm_o
);

  localparam int TAPS = 2 * K + 1;
  localparam int CW   = $clog2(TAPS + 1);

  logic signed [N-1:0] sr_q [TAPS];
  logic [CW-1:0]       cnt_q;
  logic [CW-1:0]       cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (shift_en_i && (cnt_q != CW'(TAPS))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      for (int i = 0; i < TAPS; i++) begin
        sr_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      if (shift_en_i) begin
        sr_q[0] <= din_i;
        for (int i = 1; i < TAPS; i++) begin
          sr_q[i] <= sr_q[i-1];
        end
      end
    end
  end

  assign tap0_o  = sr_q[0];
  assign tapk_o  = sr_q[K];
  assign tap2k_o = sr_q[2*K];
  // High when the next accepted sample completes a full window.
  assign warm_o  = (cnt_q >= CW'(2 * K));

endmodule

// File: rtl/neo_stream_mc.sv
// Channel-interleaved streaming NEO: psi = x[n-K]^2 - x[n]*x[n-2K], exact 2N+1 bits.
// Define NEO_THRESH_EN to add the thresh input and registered out_spike output.
module neo_stream_mc
  import neo_pkg::*;
#(
  parameter int N  = 16,
  parameter int CH = 4,
  parameter int K  = 1
) (
  input  logic                           Clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [chw(CH)-1:0]             in_ch,
  input  logic signed [N-1:0]            in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [chw(CH)-1:0]             out_ch,
  output logic signed [psi_width(N)-1:0] out_psi
`ifdef NEO_THRESH_EN
  ,
  input  logic signed [psi_width(N)-1:0] thresh,
  output logic                           out_spike
`endif
);

  localparam int CHW = chw(CH);
  localparam int PW  = psi_width(N);
  localparam int PRW = 2 * N;

  function automatic logic signed [PRW-1:0] smul(input logic signed [N-1:0] a,
                                                 input logic signed [N-1:0] b);
    logic signed [PRW-1:0] ae;
    logic signed [PRW-1:0] be;
    ae = {{N{a[N-1]}}, a};
    be = {{N{b[N-1]}}, b};
    return ae * be;
  endfunction

  function automatic logic signed [PW-1:0] psi_sub(input logic signed [PRW-1:0] a,
                                                   input logic signed [PRW-1:0] b);
    logic signed [PW-1:0] ae;
    logic signed [PW-1:0] be;
    ae = {a[PRW-1], a};
    be = {b[PRW-1], b};
    return ae - be;
  endfunction

  logic                  en1;
  logic                  en2;
  logic                  acc;
  logic [CH-1:0]         shift_w;
  logic [CH-1:0]         warm_w;
  logic signed [N-1:0]   tap0_w  [CH];
  logic signed [N-1:0]   tapk_w  [CH];
  logic signed [N-1:0]   tap2k_w [CH];
  logic                  warm_sel;
  logic signed [N-1:0]   t0_sel;
  logic signed [N-1:0]   tk_sel;
  logic signed [N-1:0]   t2k_sel;
  logic signed [PW-1:0]  psi_c;

  logic                  vld_p0;
  logic [CHW-1:0]        ch_p0;
  logic                  vld_p1;
  logic [CHW-1:0]        ch_p1;
  logic signed [PRW-1:0] sq_p1;
  logic signed [PRW-1:0] cr_p1;
  logic                  vld_p2;
  logic [CHW-1:0]        ch_p2;
  logic signed [PW-1:0]  psi_p2;

  assign en2      = !vld_p2 || out_ready;
  assign en1      = en2 || !vld_p1;
  assign in_ready = en1;
  assign acc      = in_valid && en1;

  // Ids >= CH match no tap line, so such samples are consumed without effect.
  for (genvar c = 0; c < CH; c++) begin : g_ch
    assign shift_w[c] = acc && (in_ch == CHW'(c));
    neo_tap_line #(.N(N), .K(K)) u_tap (
      .clk_i      (Clk),
      .rst_i      (reset),
      .shift_en_i (shift_w[c]),
      .din_i      (in_data),
      .tap0_o     (tap0_w[c]),
      .tapk_o     (tapk_w[c]),
      .tap2k_o    (tap2k_w[c]),
      .warm_o     (warm_w[c])
    );
  end

  always_comb begin
    warm_sel = 1'b0;
    t0_sel   = '0;
    tk_sel   = '0;
    t2k_sel  = '0;
    for (int c = 0; c < CH; c++) begin
      if (in_ch == CHW'(c)) warm_sel = warm_w[c];
      if (ch_p0 == CHW'(c)) begin
        t0_sel  = tap0_w[c];
        tk_sel  = tapk_w[c];
        t2k_sel = tap2k_w[c];
      end
    end
  end

  assign psi_c = psi_sub(sq_p1, cr_p1);

  // Stage 0: window shift on accept; stage 1: products; stage 2: difference.
  always_ff @(posedge Clk) begin
    if (reset) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      ch_p2  <= '0;
      psi_p2 <= '0;
    end else begin
      if (en1) begin
        vld_p0 <= acc && warm_sel;
        vld_p1 <= vld_p0;
      end
      if (en2) begin
        vld_p2 <= vld_p1;
      end
      if (en2 && vld_p1) begin
        ch_p2  <= ch_p1;
        psi_p2 <= psi_c;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (acc) begin
      ch_p0 <= in_ch;
    end
    if (en1 && vld_p0) begin
      ch_p1 <= ch_p0;
      sq_p1 <= smul(tk_sel, tk_sel);
      cr_p1 <= smul(t0_sel, t2k_sel);
    end
  end

`ifdef NEO_THRESH_EN
  logic spike_p2;

  always_ff @(posedge Clk) begin
    if (reset) begin
      spike_p2 <= 1'b0;
    end else if (en2 && vld_p1) begin
      spike_p2 <= (psi_c > thresh);
    end
  end

  assign out_spike = spike_p2;
`endif

  assign out_valid = vld_p2;
  assign out_ch    = ch_p2;
  assign out_psi   = psi_p2;

endmodule

// File: tb/tb_neo_stream_mc.sv
// Bench for neo_stream_mc: directed vector table, corner sequences, random scoreboard.
module tb_neo_stream_mc;

  localparam int TK = 1;

  typedef struct {
    int     ch;
    longint psi;
  } res_t;

  typedef struct {
    int     sel;
    int     ch;
    int     d;
    bit     ev;
    longint psi;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  logic               in_valid;
  logic               in_ready;
  logic [1:0]         in_ch;
  logic signed [15:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic [1:0]         out_ch;
  logic signed [32:0] out_psi;

  logic               d2_in_valid;
  logic               d2_in_ready;
  logic [0:0]         d2_in_ch;
  logic signed [15:0] d2_in_data;
  logic               d2_out_valid;
  logic               d2_out_ready;
  logic [0:0]         d2_out_ch;
  logic signed [32:0] d2_out_psi;
`ifdef NEO_THRESH_EN
  logic signed [32:0] thresh;
  logic               out_spike;
  logic signed [32:0] d2_thresh;
  logic               d2_out_spike;
`endif

  int checks = 0;
  int errors = 0;

  res_t   exp_q[$];
  res_t   got_q[$];
  longint hist[4][$];
  res_t   e;
  vec_t   tbl[$];

  always #5 clk = ~clk;

  neo_stream_mc #(.N(16), .CH(4), .K(1)) dut (
    .Clk       (clk),
    .reset     (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ch     (in_ch),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch),
    .out_psi   (out_psi)
`ifdef NEO_THRESH_EN
    ,
    .thresh    (thresh),
    .out_spike (out_spike)
`endif
  );

  neo_stream_mc #(.N(16), .CH(1), .K(2)) dut2 (
    .Clk       (clk),
    .reset     (rst),
    .in_valid  (d2_in_valid),
    .in_ready  (d2_in_ready),
    .in_ch     (d2_in_ch),
    .in_data   (d2_in_data),
    .out_valid (d2_out_valid),
    .out_ready (d2_out_ready),
    .out_ch    (d2_out_ch),
    .out_psi   (d2_out_psi)
`ifdef NEO_THRESH_EN
    ,
    .thresh    (d2_thresh),
    .out_spike (d2_out_spike)
`endif
  );

  function automatic void chk(input string name, input logic signed [63:0] act,
                              input logic signed [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, want);
    end
  endfunction

  // Reference: keep the last 2K+1 samples per channel, emit psi once the window is full.
  function automatic void model_accept(input int ch, input longint d);
    res_t r;
    hist[ch].push_back(d);
    if (hist[ch].size() > 2 * TK + 1) void'(hist[ch].pop_front());
    if (hist[ch].size() == 2 * TK + 1) begin
      r.ch  = ch;
      r.psi = hist[ch][TK] * hist[ch][TK] - hist[ch][2*TK] * hist[ch][0];
      exp_q.push_back(r);
    end
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      for (int c = 0; c < 4; c++) hist[c].delete();
    end else begin
      if (out_valid && out_ready) begin
        e.ch  = int'(out_ch);
        e.psi = longint'(out_psi);
        got_q.push_back(e);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got ch %0d psi %0d, required no result", out_ch, out_psi);
        end else begin
          e = exp_q.pop_front();
          chk("sb_ch", out_ch, e.ch);
          chk("sb_psi", out_psi, e.psi);
`ifdef NEO_THRESH_EN
          chk("sb_spike", out_spike, (e.psi > 0) ? 1 : 0);
`endif
        end
      end
      if (in_valid && in_ready) model_accept(int'(in_ch), longint'(in_data));
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input int sel, input int ch, input int d, input bit ev,
                              input longint psi);
    vec_t v;
    v.sel = sel; v.ch = ch; v.d = d; v.ev = ev; v.psi = psi;
    return v;
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0; d2_in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic send(input int ch, input int d);
    int n;
    n = 0;
    in_valid = 1'b1; in_ch = 2'(ch); in_data = 16'(d);
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready %0d required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    @(posedge clk); #1;
    if (v.sel == 0) begin
      in_valid = 1'b1; in_ch = 2'(v.ch); in_data = 16'(v.d);
    end else begin
      d2_in_valid = 1'b1; d2_in_ch = 1'(v.ch); d2_in_data = 16'(v.d);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; d2_in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk($sformatf("vec%0d_early_valid", idx), (v.sel == 0) ? out_valid : d2_out_valid, 0);
    @(posedge clk); @(negedge clk);
    if (v.sel == 0) begin
      chk($sformatf("vec%0d_valid", idx), out_valid, v.ev);
      if (v.ev) begin
        chk($sformatf("vec%0d_psi", idx), out_psi, v.psi);
        chk($sformatf("vec%0d_ch", idx), out_ch, v.ch);
`ifdef NEO_THRESH_EN
        chk($sformatf("vec%0d_spike", idx), out_spike, (v.psi > 0) ? 1 : 0);
`endif
      end
    end else begin
      chk($sformatf("vec%0d_valid", idx), d2_out_valid, v.ev);
      if (v.ev) begin
        chk($sformatf("vec%0d_psi", idx), d2_out_psi, v.psi);
        chk($sformatf("vec%0d_ch", idx), d2_out_ch, v.ch);
`ifdef NEO_THRESH_EN
        chk($sformatf("vec%0d_spike", idx), d2_out_spike, (v.psi > 0) ? 1 : 0);
`endif
      end
    end
  endtask

  initial begin
    logic signed [32:0] held_psi;
    logic [1:0]         held_ch;
    bit                 have_held;
    bit                 saw_nr;
    int                 n;

    rst = 1'b1;
    in_valid = 1'b0; in_ch = '0; in_data = '0; out_ready = 1'b1;
    d2_in_valid = 1'b0; d2_in_ch = '0; d2_in_data = '0; d2_out_ready = 1'b1;
`ifdef NEO_THRESH_EN
    thresh = '0; d2_thresh = '0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_psi", out_psi, 0);
    chk("rst_out_ch", out_ch, 0);
    chk("rst_d2_in_ready", d2_in_ready, 1);
    chk("rst_d2_out_valid", d2_out_valid, 0);
    chk("rst_d2_out_psi", d2_out_psi, 0);
`ifdef NEO_THRESH_EN
    chk("rst_out_spike", out_spike, 0);
`endif

    // Directed vectors: basic, extremes, min psi, K=2 window with stray channel id
    tbl.push_back(mk(0, 0, 3, 0, 0));
    tbl.push_back(mk(0, 0, -5, 0, 0));
    tbl.push_back(mk(0, 0, 7, 1, 4));
    tbl.push_back(mk(0, 1, 32767, 0, 0));
    tbl.push_back(mk(0, 1, -32768, 0, 0));
    tbl.push_back(mk(0, 1, -32768, 1, 64'sd2147450880));
    tbl.push_back(mk(0, 2, -32768, 0, 0));
    tbl.push_back(mk(0, 2, 0, 0, 0));
    tbl.push_back(mk(0, 2, -32768, 1, -64'sd1073741824));
    tbl.push_back(mk(1, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0));
    tbl.push_back(mk(1, 1, 100, 0, 0));
    tbl.push_back(mk(1, 0, 2, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 1, 1, 3));
    tbl.push_back(mk(1, 0, 1, 1, 0));
    tbl.push_back(mk(1, 0, 1, 1, -1));
    tbl.push_back(mk(1, 0, 1, 1, 0));
    tbl.push_back(mk(1, 0, 1, 1, 0));
    for (int i = 0; i < tbl.size(); i++) apply_vec(tbl[i], i);

    // Interleaved channels, back-to-back
    do_reset();
    got_q.delete();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++) send(c, c + 1 + r);
    repeat (6) @(posedge clk);
    #1;
    chk("ilv_count", got_q.size(), 4);
    for (int i = 0; i < got_q.size(); i++) begin
      chk($sformatf("ilv%0d_ch", i), got_q[i].ch, i);
      chk($sformatf("ilv%0d_psi", i), got_q[i].psi, 1);
    end

    // Backpressure: 10 samples, downstream stalled 5 cycles
    do_reset();
    got_q.delete();
    have_held = 1'b0;
    saw_nr = 1'b0;
    held_psi = '0;
    held_ch = '0;
    fork
      begin
        for (int i = 0; i < 10; i++) send(1, 100 * i - 450 + (i % 3) * 37);
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          if (!in_ready) saw_nr = 1'b1;
          if (out_valid) begin
            if (have_held) begin
              chk($sformatf("stall%0d_psi", i), out_psi, held_psi);
              chk($sformatf("stall%0d_ch", i), out_ch, held_ch);
            end else begin
              held_psi = out_psi;
              held_ch = out_ch;
              have_held = 1'b1;
            end
          end
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    repeat (8) @(posedge clk);
    #1;
    chk("bp_held_seen", have_held, 1);
    chk("bp_in_ready_dropped", saw_nr, 1);
    chk("bp_count", got_q.size(), 8);
    chk("bp_sb_empty", exp_q.size(), 0);

    // Reset mid-stream clears warm-up and discards in-flight results
    do_reset();
    got_q.delete();
    send(0, 5);
    send(0, 6);
    do_reset();
    send(0, 7);
    repeat (6) @(posedge clk);
    #1;
    chk("rst_warm_cleared", got_q.size(), 0);
    do_reset();
    send(0, 2);
    send(0, 3);
    send(0, 4);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_inflight_dropped", got_q.size(), 0);
    do_reset();
    send(0, 2);
    send(0, 3);
    send(0, 4);
    repeat (5) @(posedge clk);
    #1;
    chk("rst_after_count", got_q.size(), 1);
    if (got_q.size() > 0) begin
      chk("rst_after_psi", got_q[0].psi, 1);
      chk("rst_after_ch", got_q[0].ch, 0);
    end

    // Random traffic against the scoreboard
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      in_valid = ($urandom_range(0, 3) != 0);
      in_ch = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: in_data = 16'sh7fff;
        1: in_data = 16'sh8000;
        default: in_data = 16'($urandom);
      endcase
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
